// File: rtl/regfile_mp_if.sv
// Bus between the pipeline and the multi-port register file: write ports,
// read ports and the ready flag. The register file takes the slave side.
interface regfile_mp_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1
) ();
    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic                 ready;
    logic [NWR-1:0]       we;
    logic [NWR*AW-1:0]    wa;
    logic [NWR*XLEN-1:0]  wd;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*XLEN-1:0]  rd;

    modport master (
        input  ready,
        input  rd,
        output we,
        output wa,
        output wd,
        output ra
    );

    modport slave (
        output ready,
        output rd,
        input  we,
        input  wa,
        input  wd,
        input  ra
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file.
// NRD combinational read ports, NWR write ports (highest index wins on a
// shared address), same-cycle write-to-read bypass, x0 hardwired to zero.
// After reset the array is cleared one entry per cycle before ready rises.
module regfile_mp #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1
) (
    input  logic          clk,
    input  logic          rst,
    regfile_mp_if.slave   bus
);
    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                          state;
    logic [AW-1:0]                   ptr;
    logic                            ready_q;

    // x0 has no storage; entries 1..NREGS-1 only
    logic [XLEN-1:0]                 mem [1:NREGS-1];

    logic [NWR-1:0][AW-1:0]          wa_v;
    logic [NWR-1:0][XLEN-1:0]        wd_v;
    logic [NRD-1:0][XLEN-1:0]        rd_v;

    // Valid architectural, non-zero register index
    function automatic logic in_range(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < NREGS);
    endfunction

    // Split the flat write buses into per-port fields
    always_comb begin
        wa_v = '0;
        wd_v = '0;
        for (int unsigned i = 0; i < NWR; i++) begin
            wa_v[i] = bus.wa[i*AW +: AW];
            wd_v[i] = bus.wd[i*XLEN +: XLEN];
        end
    end

    // Sweep/run sequencing with registered ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SWEEP;
            ptr     <= AW'(1);
            ready_q <= 1'b0;
        end else begin
            case (state)
                SWEEP: begin
                    if (32'(ptr) == NREGS - 1) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                RUN: begin
                    state   <= RUN;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= SWEEP;
                    ptr     <= AW'(1);
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Array update: sweep clears one entry per cycle; in RUN the ports are
    // applied in ascending order so the last (highest-index) write wins
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == SWEEP) begin
                mem[ptr] <= '0;
            end else begin
                for (int unsigned i = 0; i < NWR; i++) begin
                    if (bus.we[i] && in_range(wa_v[i])) begin
                        mem[wa_v[i]] <= wd_v[i];
                    end
                end
            end
        end
    end

    // Combinational reads; bypass scan uses the same ascending order as the
    // array write so a read always equals what the next edge stores
    always_comb begin
        rd_v = '0;
        for (int unsigned j = 0; j < NRD; j++) begin
            if (ready_q && in_range(bus.ra[j*AW +: AW])) begin
                rd_v[j] = mem[bus.ra[j*AW +: AW]];
                for (int unsigned i = 0; i < NWR; i++) begin
                    if (bus.we[i] && (wa_v[i] == bus.ra[j*AW +: AW])) begin
                        rd_v[j] = wd_v[i];
                    end
                end
            end
        end
    end

    assign bus.rd    = rd_v;
    assign bus.ready = ready_q;

endmodule
